// File: rtl/icache_pkg.sv
// Shared widths and FSM state encoding for the direct-mapped instruction cache.
package icache_pkg;
    localparam int INS_DAT_W = 32;
    localparam int REG_DAT_W = 32;

    typedef enum logic [1:0] {
        IC_IDLE  = 2'd0,
        IC_MISS  = 2'd1,
        IC_ABORT = 2'd2
    } ic_state_t;
endpackage

// File: rtl/icache_mem.sv
// Valid/tag/data storage: one word per line, synchronous write, combinational hit lookup.
module icache_mem
    import icache_pkg::*;
#(
    parameter int IDX_W = 8,
    parameter int TAG_W = REG_DAT_W - IDX_W - 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [IDX_W-1:0]     widx,
    input  logic [TAG_W-1:0]     wtag,
    input  logic [INS_DAT_W-1:0] wdat,
    input  logic [IDX_W-1:0]     ridx,
    input  logic [TAG_W-1:0]     rtag,
    output logic                 hit,
    output logic [INS_DAT_W-1:0] rdat
);
    localparam int LINES = 1 << IDX_W;

    logic [LINES-1:0]     vld;
    logic [TAG_W-1:0]     tags [LINES];
    logic [INS_DAT_W-1:0] dats [LINES];

    // Only the valid bits need reset; stale tag/data are masked by them.
    always_ff @(posedge clk) begin
        if (rst)
            vld <= '0;
        else if (we)
            vld[widx] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (we) begin
            tags[widx] <= wtag;
            dats[widx] <= wdat;
        end
    end

    assign hit  = vld[ridx] && (tags[ridx] == rtag);
    assign rdat = dats[ridx];
endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache top: FSM, request registers, optional hit/miss
// counters enabled by defining ICACHE_STAT_EN.
module icache
    import icache_pkg::*;
#(
    parameter int IDX_W = 8,
    parameter int TAG_W = REG_DAT_W - IDX_W - 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 iFlush,
    input  logic                 iIF_En,
    input  logic [REG_DAT_W-1:0] iIF_Addr,
    output logic                 oIF_Rdy,
    output logic                 oIF_En,
    output logic [INS_DAT_W-1:0] oIF_Ins,
    output logic                 oMC_En,
    output logic [REG_DAT_W-1:0] oMC_Addr,
    input  logic                 iMC_En,
    input  logic [INS_DAT_W-1:0] iMC_Dat
`ifdef ICACHE_STAT_EN
    ,
    output logic [31:0]          oStat_Hit,
    output logic [31:0]          oStat_Miss
`endif
);
    ic_state_t            state;
    logic                 hit;
    logic [INS_DAT_W-1:0] rdat;
    logic                 req;
    logic                 fill;
    logic [1:0]           unused_addr_lsb;

    assign unused_addr_lsb = iIF_Addr[1:0];

    // A flush in the same cycle as a request kills the request outright.
    assign req  = en && (state == IC_IDLE) && iIF_En && !iFlush;
    // The line is filled on MC return even when the miss was aborted.
    assign fill = en && (state != IC_IDLE) && iMC_En;

    icache_mem #(.IDX_W(IDX_W), .TAG_W(TAG_W)) u_mem (
        .clk  (clk),
        .rst  (rst),
        .we   (fill),
        .widx (oMC_Addr[IDX_W+1:2]),
        .wtag (oMC_Addr[REG_DAT_W-1:IDX_W+2]),
        .wdat (iMC_Dat),
        .ridx (iIF_Addr[IDX_W+1:2]),
        .rtag (iIF_Addr[REG_DAT_W-1:IDX_W+2]),
        .hit  (hit),
        .rdat (rdat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IC_IDLE;
            oIF_Rdy  <= 1'b1;
            oIF_En   <= 1'b0;
            oIF_Ins  <= '0;
            oMC_En   <= 1'b0;
            oMC_Addr <= '0;
        end else if (en) begin
            oIF_En <= 1'b0;
            unique case (state)
                IC_IDLE: begin
                    if (req) begin
                        if (hit) begin
                            oIF_En  <= 1'b1;
                            oIF_Ins <= rdat;
                        end else begin
                            oMC_En   <= 1'b1;
                            oMC_Addr <= {iIF_Addr[REG_DAT_W-1:2], 2'b00};
                            oIF_Rdy  <= 1'b0;
                            state    <= IC_MISS;
                        end
                    end
                end
                IC_MISS: begin
                    if (iMC_En) begin
                        oMC_En  <= 1'b0;
                        oIF_Rdy <= 1'b1;
                        state   <= IC_IDLE;
                        if (!iFlush) begin
                            oIF_En  <= 1'b1;
                            oIF_Ins <= iMC_Dat;
                        end
                    end else if (iFlush) begin
                        state <= IC_ABORT;
                    end
                end
                IC_ABORT: begin
                    // MC cannot be cancelled: keep requesting until the word lands.
                    if (iMC_En) begin
                        oMC_En  <= 1'b0;
                        oIF_Rdy <= 1'b1;
                        state   <= IC_IDLE;
                    end
                end
                default: state <= IC_IDLE;
            endcase
        end
    end

`ifdef ICACHE_STAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            oStat_Hit  <= '0;
            oStat_Miss <= '0;
        end else if (req) begin
            if (hit)
                oStat_Hit  <= oStat_Hit + 32'd1;
            else
                oStat_Miss <= oStat_Miss + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: driver pushes expected responses, a negedge monitor checks them.
module tb_icache;
    logic        clk = 1'b0;
    logic        rst, en, iFlush, iIF_En, iMC_En;
    logic [31:0] iIF_Addr, iMC_Dat;
    logic        oIF_Rdy, oIF_En, oMC_En;
    logic [31:0] oIF_Ins, oMC_Addr;
`ifdef ICACHE_STAT_EN
    logic [31:0] oStat_Hit, oStat_Miss;
`endif

    icache dut (
        .clk(clk), .rst(rst), .en(en), .iFlush(iFlush), .iIF_En(iIF_En),
        .iIF_Addr(iIF_Addr), .oIF_Rdy(oIF_Rdy), .oIF_En(oIF_En), .oIF_Ins(oIF_Ins),
        .oMC_En(oMC_En), .oMC_Addr(oMC_Addr), .iMC_En(iMC_En), .iMC_Dat(iMC_Dat)
`ifdef ICACHE_STAT_EN
        , .oStat_Hit(oStat_Hit), .oStat_Miss(oStat_Miss)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] dat; int due; } rsp_t;
    rsp_t rq[$];

    int checks = 0, failures = 0, cyc = 0;
    int n_hit = 0, n_miss = 0;
    bit mon_on = 0, exp_rdy = 1, exp_mc = 0;
    logic [31:0] exp_mc_addr = '0;

    // Reference cache: per-index valid, full word address and data.
    bit          mv [256];
    logic [31:0] ma [256];
    logic [31:0] md [256];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] memw(input logic [31:0] a);
        if (a == 32'h0000_1000) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            rsp_t r;
            chk("oIF_Rdy", {31'd0, oIF_Rdy}, {31'd0, exp_rdy});
            chk("oMC_En", {31'd0, oMC_En}, {31'd0, exp_mc});
            if (exp_mc) chk("oMC_Addr", oMC_Addr, exp_mc_addr);
            if (oIF_En === 1'b1) begin
                if (rq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_rsp: got oIF_En=1 ins=%h at cyc %0d expected none", oIF_Ins, cyc);
                end else begin
                    r = rq.pop_front();
                    chk("rsp_data", oIF_Ins, r.dat);
                    chk("rsp_cycle", cyc, r.due);
                end
            end else if (rq.size() > 0 && rq[0].due <= cyc) begin
                checks++; failures++;
                $display("FAIL missing_rsp: got oIF_En=0 at cyc %0d expected data %h", cyc, rq[0].dat);
                void'(rq.pop_front());
            end
        end
    end

    task automatic fetch(input logic [31:0] addr, input int flush_at, input bit flush_mc, input bit stall);
        logic [31:0] wa;
        int idx, dly;
        bit flushed;
        rsp_t r;
        wa  = {addr[31:2], 2'b00};
        idx = int'(addr[9:2]);
        iIF_En = 1; iIF_Addr = addr;
        if (mv[idx] && ma[idx] == wa) begin
            r.dat = md[idx]; r.due = cyc + 1; rq.push_back(r); n_hit++;
            tick(); iIF_En = 0;
            return;
        end
        n_miss++;
        tick(); iIF_En = 0;
        exp_mc = 1; exp_mc_addr = wa; exp_rdy = 0;
        dly = (flush_at >= 0) ? flush_at + 1 + int'($urandom_range(0, 2)) : int'($urandom_range(1, 4));
        flushed = 0;
        for (int i = 0; i < dly; i++) begin
            if (i == flush_at) iFlush = 1;
            if ($urandom_range(0, 3) == 0) begin iIF_En = 1; iIF_Addr = $urandom; end
            tick();
            if (iFlush) flushed = 1;
            iFlush = 0; iIF_En = 0;
            if (stall && i == 0) begin
                en = 0; repeat (3) tick(); en = 1;
            end
        end
        iMC_En = 1; iMC_Dat = memw(wa);
        if (flush_mc) iFlush = 1;
        if (!flushed && !flush_mc) begin r.dat = memw(wa); r.due = cyc + 1; rq.push_back(r); end
        tick();
        iMC_En = 0; iFlush = 0; iMC_Dat = $urandom;
        exp_mc = 0; exp_rdy = 1;
        mv[idx] = 1; ma[idx] = wa; md[idx] = memw(wa);
    endtask

    task automatic flush_req(input logic [31:0] addr);
        iIF_En = 1; iIF_Addr = addr; iFlush = 1;
        tick();
        iIF_En = 0; iFlush = 0;
    endtask

    // Hit whose response is frozen by en=0 for two cycles: pulse held three cycles.
    task automatic hit_stall(input logic [31:0] addr);
        int idx;
        rsp_t r;
        idx = int'(addr[9:2]);
        if (!(mv[idx] && ma[idx] == {addr[31:2], 2'b00})) begin
            fetch(addr, -1, 0, 0);
            return;
        end
        for (int k = 1; k <= 3; k++) begin r.dat = md[idx]; r.due = cyc + k; rq.push_back(r); end
        n_hit++;
        iIF_En = 1; iIF_Addr = addr;
        tick(); iIF_En = 0; en = 0;
        tick(); tick(); en = 1;
    endtask

    task automatic rst_miss(input logic [31:0] addr);
        iIF_En = 1; iIF_Addr = addr;
        tick(); iIF_En = 0;
        exp_mc = 1; exp_mc_addr = {addr[31:2], 2'b00}; exp_rdy = 0;
        tick(); tick();
        rst = 1;
        tick(); rst = 0;
        exp_mc = 0; exp_rdy = 1;
        for (int i = 0; i < 256; i++) mv[i] = 0;
        n_hit = 0; n_miss = 0;
        chk("rst_oIF_En", {31'd0, oIF_En}, 32'd0);
        chk("rst_oIF_Ins", oIF_Ins, 32'd0);
        chk("rst_oMC_Addr", oMC_Addr, 32'd0);
    endtask

    initial begin
        rst = 1; en = 1; iFlush = 0; iIF_En = 0; iIF_Addr = '0; iMC_En = 0; iMC_Dat = '0;
        for (int i = 0; i < 256; i++) begin mv[i] = 0; ma[i] = '0; md[i] = '0; end
        tick(); tick();
        rst = 0;
        chk("reset_oIF_Rdy", {31'd0, oIF_Rdy}, 32'd1);
        chk("reset_oIF_En", {31'd0, oIF_En}, 32'd0);
        chk("reset_oIF_Ins", oIF_Ins, 32'd0);
        chk("reset_oMC_En", {31'd0, oMC_En}, 32'd0);
        chk("reset_oMC_Addr", oMC_Addr, 32'd0);
        mon_on = 1;
        tick();

        fetch(32'h0000_1000, -1, 0, 0);   // cold miss
        fetch(32'h0000_1000, -1, 0, 0);   // hit
        fetch(32'h0000_1004, -1, 0, 0);   // preload
        fetch(32'h0000_1000, -1, 0, 0);   // back-to-back hits
        fetch(32'h0000_1004, -1, 0, 0);
        fetch(32'h0000_1400, -1, 0, 0);   // conflict evicts 0x1000
        fetch(32'h0000_1000, -1, 0, 0);
        fetch(32'h0000_2000,  2, 0, 0);   // flush mid-miss
        fetch(32'h0000_2000, -1, 0, 0);   // line still filled
        flush_req(32'h0000_1000);
        fetch(32'h0000_3000, -1, 0, 1);   // en=0 during MISS
        fetch(32'h0000_3004, -1, 1, 0);   // flush together with iMC_En
        fetch(32'h0000_3004, -1, 0, 0);
        hit_stall(32'h0000_3000);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            int sel;
            a = 32'h0000_1000 + ($urandom_range(0, 3) << 10) + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
            sel = int'($urandom_range(0, 19));
            if (sel == 0)      flush_req(a);
            else if (sel == 1) fetch(a, int'($urandom_range(0, 2)), 0, 0);
            else if (sel == 2) fetch(a, -1, 1, 0);
            else if (sel == 3) fetch(a, -1, 0, 1);
            else if (sel == 4) hit_stall(a);
            else               fetch(a, -1, 0, 0);
            if ($urandom_range(0, 4) == 0) tick();
        end
`ifdef ICACHE_STAT_EN
        chk("stat_hit", oStat_Hit, n_hit);
        chk("stat_miss", oStat_Miss, n_miss);
`endif

        fetch(32'h0000_1000, -1, 0, 0);
        rst_miss(32'h0000_7ff0);
        fetch(32'h0000_1000, -1, 0, 0);   // cached before reset, must miss now
        fetch(32'h0000_1000, -1, 0, 0);
        tick(); tick();
`ifdef ICACHE_STAT_EN
        chk("stat_hit_post_rst", oStat_Hit, n_hit);
        chk("stat_miss_post_rst", oStat_Miss, n_miss);
`endif
        chk("rsp_queue_drained", rq.size(), 32'd0);
        mon_on = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
